// File: rtl/x25519_ladder_ctrl.sv
// X25519 Montgomery ladder sequencer: walks the clamped scalar MSB-first, feeds the
// ladder-step core with constant-time swapped operands and collects its outputs.
module x25519_ladder_ctrl #(
  parameter int STEP_LEN = 13,
  parameter int A24      = 121666
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] scalar,
  input  logic [255:0] u_in,
  output logic         ready,
  output logic         done,
  output logic [255:0] out_x,
  output logic [255:0] out_z,
  output logic         step_rst,
  output logic [255:0] step_x1,
  output logic [255:0] step_x2,
  output logic [255:0] step_z2,
  output logic [255:0] step_x3,
  output logic [255:0] step_z3,
  input  logic [255:0] step_x2n,
  input  logic [255:0] step_z2n,
  input  logic [255:0] step_x3n,
  input  logic [255:0] step_z3n
);

  localparam logic [3:0]   LAST_PH = 4'(STEP_LEN - 1);
  localparam logic [255:0] K_CLR   = ~((256'd1 << 255) | 256'd7);
  localparam logic [255:0] K_SET   = 256'd1 << 254;
  localparam logic [255:0] U_MSK   = ~(256'd1 << 255);

  // The step core owns the curve constant; reject a nonsensical override early.
  if (A24 <= 0) begin : g_a24_chk
    $error("A24 must be positive");
  end

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FINAL = 2'd2} state_t;

  state_t       state_q, state_d;
  logic [255:0] k_q, k_d, x1_q, x1_d;
  logic [255:0] x2_q, x2_d, z2_q, z2_d, x3_q, x3_d, z3_q, z3_d;
  logic [255:0] cx2_q, cx2_d, cx3_q, cx3_d, cz2_q, cz2_d;
  logic [255:0] ox_q, ox_d, oz_q, oz_d;
  logic [7:0]   t_q, t_d;
  logic [3:0]   phase_q, phase_d;
  logic         swap_q, swap_d, done_q, done_d;

  logic         s_eff, swap_n;
  logic [255:0] sw_mask, fin_mask, dx, dz;

  // Constant-time conditional swap: XOR mask derived from the effective swap bit.
  always_comb begin
    s_eff    = swap_q ^ k_q[t_q];
    swap_n   = k_q[t_q];
    sw_mask  = {256{s_eff}};
    fin_mask = {256{swap_n}};
    dx       = (x2_q ^ x3_q) & sw_mask;
    dz       = (z2_q ^ z3_q) & sw_mask;
  end

  assign step_x1  = x1_q;
  assign step_x2  = x2_q ^ dx;
  assign step_z2  = z2_q ^ dz;
  assign step_x3  = x3_q ^ dx;
  assign step_z3  = z3_q ^ dz;
  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign out_x    = ox_q;
  assign out_z    = oz_q;
  // Phase 12 re-zeroes the step counter so every iteration starts aligned.
  assign step_rst = !((state_q == RUN) && (phase_q != LAST_PH));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    z2_d    = z2_q;
    x3_d    = x3_q;
    z3_d    = z3_q;
    cx2_d   = cx2_q;
    cx3_d   = cx3_q;
    cz2_d   = cz2_q;
    ox_d    = ox_q;
    oz_d    = oz_q;
    t_d     = t_q;
    phase_d = phase_q;
    swap_d  = swap_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = (scalar & K_CLR) | K_SET;
          x1_d    = u_in & U_MSK;
          x2_d    = 256'd1;
          z2_d    = 256'd0;
          x3_d    = u_in & U_MSK;
          z3_d    = 256'd1;
          t_d     = 8'd254;
          swap_d  = 1'b0;
          phase_d = 4'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (phase_q == 4'd7)  cx2_d = step_x2n;
        if (phase_q == 4'd10) cx3_d = step_x3n;
        if (phase_q == 4'd11) cz2_d = step_z2n;
        if (phase_q == LAST_PH) begin
          x2_d    = cx2_q;
          z2_d    = cz2_q;
          x3_d    = cx3_q;
          z3_d    = step_z3n;
          swap_d  = swap_n;
          phase_d = 4'd0;
          if (t_q == 8'd0) begin
            // Result is latched on entry to FINAL so it is valid alongside done.
            ox_d    = cx2_q ^ ((cx2_q ^ cx3_q) & fin_mask);
            oz_d    = cz2_q ^ ((cz2_q ^ step_z3n) & fin_mask);
            done_d  = 1'b1;
            state_d = FINAL;
          end else begin
            t_d = t_q - 8'd1;
          end
        end else begin
          phase_d = phase_q + 4'd1;
        end
      end
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      z2_q    <= '0;
      x3_q    <= '0;
      z3_q    <= '0;
      cx2_q   <= '0;
      cx3_q   <= '0;
      cz2_q   <= '0;
      ox_q    <= '0;
      oz_q    <= '0;
      t_q     <= '0;
      phase_q <= '0;
      swap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      z2_q    <= z2_d;
      x3_q    <= x3_d;
      z3_q    <= z3_d;
      cx2_q   <= cx2_d;
      cx3_q   <= cx3_d;
      cz2_q   <= cz2_d;
      ox_q    <= ox_d;
      oz_q    <= oz_d;
      t_q     <= t_d;
      phase_q <= phase_d;
      swap_q  <= swap_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_x25519_ladder_ctrl.sv
// Bench for x25519_ladder_ctrl: behavioural step core, software ladder reference
// over GF(2^255-19), RFC 7748 vector, reset/abort and ignored-start scenarios.
module tb_x25519_ladder_ctrl;

  typedef logic [511:0] w_t;
  localparam logic [255:0] P  = (256'd1 << 255) - 256'd19;
  localparam w_t           PW = {256'd0, P};

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [255:0] scalar = '0, u_in = '0;
  logic         ready, done, step_rst;
  logic [255:0] out_x, out_z;
  logic [255:0] step_x1, step_x2, step_z2, step_x3, step_z3;
  logic [255:0] step_x2n, step_z2n, step_x3n, step_z3n;

  int tests = 0;
  int fails = 0;

  x25519_ladder_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .scalar(scalar), .u_in(u_in),
    .ready(ready), .done(done), .out_x(out_x), .out_z(out_z),
    .step_rst(step_rst),
    .step_x1(step_x1), .step_x2(step_x2), .step_z2(step_z2),
    .step_x3(step_x3), .step_z3(step_z3),
    .step_x2n(step_x2n), .step_z2n(step_z2n),
    .step_x3n(step_x3n), .step_z3n(step_z3n)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] b);
    w_t r = ({256'd0, a} + {256'd0, b}) % PW;
    return r[255:0];
  endfunction

  function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] b);
    w_t r = (({256'd0, a} % PW) + PW - ({256'd0, b} % PW)) % PW;
    return r[255:0];
  endfunction

  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] b);
    w_t r = ({256'd0, a} * {256'd0, b}) % PW;
    return r[255:0];
  endfunction

  function automatic logic [255:0] finv(input logic [255:0] z);
    logic [255:0] r = 256'd1;
    logic [255:0] e = P - 256'd2;
    for (int i = 254; i >= 0; i--) begin
      r = fmul(r, r);
      if (e[i]) r = fmul(r, z);
    end
    return r;
  endfunction

  // RFC 7748 ladder step; returns {x2', z2', x3', z3'}.
  function automatic logic [1023:0] ladder_step(input logic [255:0] x1, x2, z2, x3, z3);
    logic [255:0] a, aa, b, bb, e, c, d, da, cb;
    a  = fadd(x2, z2);  aa = fmul(a, a);
    b  = fsub(x2, z2);  bb = fmul(b, b);
    e  = fsub(aa, bb);
    c  = fadd(x3, z3);  d  = fsub(x3, z3);
    da = fmul(d, a);    cb = fmul(c, b);
    return {fmul(aa, bb), fmul(e, fadd(bb, fmul(256'd121666, e))),
            fmul(fadd(da, cb), fadd(da, cb)),
            fmul(x1, fmul(fsub(da, cb), fsub(da, cb)))};
  endfunction

  function automatic logic [255:0] le256(input logic [255:0] be);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = be[255-8*i -: 8];
    return r;
  endfunction

  // Behavioural step core: 11-state counter, each output real only in its slot.
  int           cnt = 0;
  logic [255:0] junk = '0;
  logic [255:0] r_x2, r_z2, r_x3, r_z3;
  always @(posedge clk) begin
    cnt  <= step_rst ? 0 : ((cnt == 10) ? 0 : cnt + 1);
    junk <= {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  end
  always_comb begin
    {r_x2, r_z2, r_x3, r_z3} = ladder_step(step_x1, step_x2, step_z2, step_x3, step_z3);
  end
  assign step_x2n = (cnt == 7)  ? r_x2 : junk;
  assign step_x3n = (cnt == 10) ? r_x3 : junk;
  assign step_z2n = (cnt == 0)  ? r_z2 : junk;
  assign step_z3n = (cnt == 1)  ? r_z3 : junk;

  // Software reference ladder results
  logic [255:0] e_x2 [0:254];
  logic [255:0] e_z2 [0:254];
  logic [255:0] e_x3 [0:254];
  logic [255:0] e_z3 [0:254];
  logic [255:0] exp_x1, exp_px, exp_pz, exp_aff, dut_aff;

  task automatic sw_ladder(input logic [255:0] sc, input logic [255:0] u);
    logic [255:0] k, x1, x2, z2, x3, z3, tmp;
    logic sw, kt;
    k  = (sc & ~((256'd1 << 255) | 256'd7)) | (256'd1 << 254);
    x1 = u; x1[255] = 1'b0;
    x2 = 256'd1; z2 = 256'd0; x3 = x1; z3 = 256'd1; sw = 1'b0;
    for (int t = 254; t >= 0; t--) begin
      kt = k[t];
      sw = sw ^ kt;
      if (sw) begin
        tmp = x2; x2 = x3; x3 = tmp;
        tmp = z2; z2 = z3; z3 = tmp;
      end
      e_x2[254-t] = x2; e_z2[254-t] = z2; e_x3[254-t] = x3; e_z3[254-t] = z3;
      {x2, z2, x3, z3} = ladder_step(x1, x2, z2, x3, z3);
      sw = kt;
    end
    if (sw) begin
      tmp = x2; x2 = x3; x3 = tmp;
      tmp = z2; z2 = z3; z3 = tmp;
    end
    exp_x1  = x1;
    exp_px  = x2;
    exp_pz  = z2;
    exp_aff = fmul(x2, finv(z2));
  endtask

  task automatic chk(input string tag, input string name, input logic [255:0] got,
                     input logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s/%s: got %h expected %h", tag, name, got, exp);
    end
  endtask

  task automatic run_op(input logic [255:0] sc, input logic [255:0] u, input bit pulse,
                        input int abort_at, input string tag);
    int first_done, ndone, it, ph;
    logic [12:0]   rstv;
    logic [1279:0] snap, cur, expv;
    logic [255:0]  gx, gz;
    bit seen;
    sw_ladder(sc, u);
    chk(tag, "ready_pre", 256'(ready), 256'd1);
    scalar = sc; u_in = u; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    scalar = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    u_in   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    first_done = -1; ndone = 0; rstv = '0; snap = '0; gx = '0; gz = '0;
    for (int cyc = 1; cyc <= 3320; cyc++) begin
      if (cyc == abort_at) begin
        rst = 1'b1; #1;
        chk(tag, "ready_on_rst", 256'(ready), 256'd1);
        chk(tag, "out_x_on_rst", out_x, 256'd0);
        chk(tag, "out_z_on_rst", out_z, 256'd0);
        chk(tag, "step_rst_on_rst", 256'(step_rst), 256'd1);
        @(posedge clk); #1;
        rst = 1'b0; seen = 1'b0;
        repeat (20) begin
          seen = seen | done;
          @(posedge clk); #1;
        end
        chk(tag, "no_done_after_rst", 256'(seen), 256'd0);
        return;
      end
      start = pulse && (cyc == 5 || cyc == 2000);
      if (done) begin
        ndone++;
        if (first_done < 0) begin
          first_done = cyc; gx = out_x; gz = out_z;
        end
      end
      if (cyc <= 3315) begin
        ph = (cyc - 1) % 13;
        it = (cyc - 1) / 13;
        rstv[ph] = step_rst;
        cur = {step_x1, step_x2, step_z2, step_x3, step_z3};
        if (ph == 0) snap = cur;
        if (ph == 12) begin
          chk(tag, "step_rst_wave", 256'(rstv), 256'h1000);
          expv = {exp_x1, e_x2[it], e_z2[it], e_x3[it], e_z3[it]};
          tests++;
          assert (snap === cur && cur === expv) else begin
            fails++;
            $error("FAIL %s/step_in[%0d]: got x2=%h expected x2=%h stable=%0d",
                   tag, it, step_x2, e_x2[it], snap === cur);
          end
        end
      end
      if (cyc == 3317) begin
        chk(tag, "ready_after", 256'(ready), 256'd1);
        chk(tag, "out_x_held", out_x, exp_px);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk(tag, "done_cycle", 256'(first_done), 256'd3316);
    chk(tag, "done_count", 256'(ndone), 256'd1);
    chk(tag, "out_x_proj", gx, exp_px);
    chk(tag, "out_z_proj", gz, exp_pz);
    dut_aff = fmul(gx, finv(gz));
    chk(tag, "affine", dut_aff, exp_aff);
  endtask

  logic [255:0] rfc_k, rfc_u, rfc_out;

  initial begin
    rfc_k   = le256(256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4);
    rfc_u   = le256(256'he6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c);
    rfc_out = le256(256'hc3da55379de9c6908e94ea4df28d084f32eccf03491c71f754b4075577a28552);

    repeat (3) @(posedge clk);
    #1;
    chk("reset", "ready", 256'(ready), 256'd1);
    chk("reset", "done", 256'(done), 256'd0);
    chk("reset", "step_rst", 256'(step_rst), 256'd1);
    chk("reset", "out_x", out_x, 256'd0);
    chk("reset", "out_z", out_z, 256'd0);
    chk("reset", "step_words", step_x1 | step_x2 | step_z2 | step_x3 | step_z3, 256'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(rfc_k, rfc_u, 1'b0, 0, "rfc");
    chk("rfc", "vs_rfc", dut_aff, rfc_out);

    run_op(rfc_k | 256'd7 | (256'd1 << 255), rfc_u | (256'd1 << 255), 1'b1, 0, "rfc_dirty");
    chk("rfc_dirty", "vs_rfc", dut_aff, rfc_out);

    run_op({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
           1'b0, 1500, "abort");
    run_op(rfc_k, rfc_u, 1'b0, 0, "rfc_after_rst");
    chk("rfc_after_rst", "vs_rfc", dut_aff, rfc_out);

    run_op(256'd0, 256'd9, 1'b0, 0, "k0_u9");

    run_op({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
           1'b0, 0, "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/x25519_ladder_ctrl.md
# x25519_ladder_ctrl

Sequencer that runs the full X25519 Montgomery ladder over a 255-bit clamped scalar. It sits directly upstream of the ladder-step datapath and feeds it. Each iteration it applies the constant-time conditional swap, presents (X1, X2, Z2, X3, Z3) to the step core, and captures the step core's four time-multiplexed outputs in their valid cycles. On completion it hands the projective result (X, Z) to the downstream inversion stage.

## Interface
Parameters:
- STEP_LEN, 13, cycles per ladder iteration (phases 0..12).
- A24, 121666, informational only; the step core applies this constant internally.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only when ready=1.
- scalar  in  256  raw scalar k, little-endian integer.
- u_in  in  256  input u-coordinate; bit 255 is ignored.
- ready  out  1  high in IDLE.
- done  out  1  one-cycle pulse when out_x/out_z become valid.
- out_x, out_z  out  256  projective result; held until the next accept.
- step_rst  out  1  drives the step core's synchronous reset.
- step_x1, step_x2, step_z2, step_x3, step_z3  out  256  step core inputs.
- step_x2n, step_z2n, step_x3n, step_z3n  in  256  step core outputs.

## Operation
- States are IDLE, RUN and FINAL.
- IDLE:
  - ready=1.
  - On start=1 at a clock edge, the controller loads its registers:
    - k ← scalar with bits 0, 1, 2 and 255 cleared and bit 254 set.
    - x1 ← u_in with bit 255 cleared.
    - x2=1, z2=0, x3=x1, z3=1.
    - t=254, swap=0, phase=0.
  - It then goes to RUN.
- RUN:
  - Effective swap is s = swap XOR k[t].
  - step_x2/step_z2 = s ? (x3,z3) : (x2,z2).
  - step_x3/step_z3 = s ? (x2,z2) : (x3,z3).
  - step_x1 = x1.
  - The swap is implemented as an XOR mask, not a data-dependent branch.
- Capture registers, loaded at the edge ending each phase:
  - Phase 7 ← step_x2n.
  - Phase 10 ← step_x3n.
  - Phase 11 ← step_z2n.
- Phase 12 edge:
  - x2, x3, z2 ← captured values; z3 ← step_z3n, taken live.
  - swap ← k[t], phase ← 0.
  - If t==0, go to FINAL; otherwise t ← t−1.
- Any other RUN edge: phase ← phase+1.
- FINAL (one cycle):
  - out_x ← swap ? x3 : x2.
  - out_z ← swap ? z3 : z2.
  - done=1 for this cycle only, then go to IDLE.
- step_rst = NOT(state==RUN AND phase≤11).
  - This holds the step core's counter at 0 outside an iteration.
  - It returns the counter to 0 during phase 12, so each iteration starts aligned.
- All arithmetic is done by the step core. The controller only moves 256-bit words and never performs modular operations.

## Timing
- Reset values:
  - State IDLE, ready=1, done=0, step_rst=1.
  - out_x, out_z and all step_* outputs are 0.
  - All internal registers are 0.
- Latency:
  - The accept edge is cycle 0.
  - RUN occupies cycles 1..3315, i.e. 255×13 cycles.
  - done is high in cycle 3316 after the accept edge, with out_x/out_z valid in the same cycle.
  - The earliest next accept is the edge ending cycle 3317 (IDLE).
- Step-core alignment with step_rst:
  - Phase 0 is step counter 0 and phase k is step counter k for k≤10.
  - Phase 11 is counter 0 again and phase 12 is counter 1.
- start while not IDLE is ignored, with no queueing. start and done never overlap because done occurs in FINAL.
- Scalar and u_in are sampled only at the accept edge; later changes have no effect.
- Reset mid-operation:
  - Immediate return to IDLE.
  - out_x/out_z cleared, done never pulses.
  - step_rst asserted asynchronously.

## Test plan
- RFC 7748 vector 1:
  - Stimulus: scalar=a546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4, u=e6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c (little-endian byte strings).
  - Required: bench computes out_x·out_z^(p−2) mod p = c3da55379de9c6908e94ea4df28d084f32eccf03491c71f754b4075577a28552; done exactly 3316 cycles after accept.
- u_in with bit 255 set gives the same result as with bit 255 clear. A scalar with bits 0..2 and 255 set gives the same result as with them cleared.
- step_rst waveform over one iteration:
  - Required: low for phases 0..11, high in phase 12.
  - Required: step_x2..z3 stable throughout each iteration and swapped exactly when swap XOR k[t]=1; checked against a reference model with a behavioural step core.
- start pulsed at cycles 5 and 2000 after an accept: both ignored, result unchanged, a single done pulse.
- rst asserted at cycle 1500 of an operation:
  - Required: ready=1 and out_x=out_z=0 immediately.
  - Required: a new start then completes correctly with the RFC vector.
- Scalar with all relevant bits zero (k=2^254 after clamping), u=9:
  - Required: result matches the software ladder.
  - Required: done held low except for exactly one cycle.
